// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit that owns the architectural HI/LO registers.
// mult/multu/div/divu are computed in full when the unit accepts them and held
// internally. The unit then stays busy for a fixed latency and commits the result
// to HI/LO when that latency runs out. mthi/mtlo write HI/LO directly and only
// while the unit is idle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no operation in flight; mthi/mtlo/accept allowed
// S_BUSY | operation in flight; counter runs down, commit on 1->0
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [31:0]      r_res_hi, w_res_hi_nxt;
  logic [31:0]      r_res_lo, w_res_lo_nxt;
  logic             r_res_wr, w_res_wr_nxt;
  logic [31:0]      r_hi,     w_hi_nxt;
  logic [31:0]      r_lo,     w_lo_nxt;

  // MDOp[0] selects the unsigned flavour for both mult and div.
  logic        w_unsigned;
  logic        w_is_md;
  logic        w_is_div;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_b_zero;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_unsigned = MDOp[0];
  assign w_is_div   = MDOp[1];
  assign w_is_md    = start & ~MDOp[2];

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // correct for both flavours.
  assign w_mul_a = w_unsigned ? {32'h0, rs} : {{32{rs[31]}}, rs};
  assign w_mul_b = w_unsigned ? {32'h0, rt} : {{32{rt[31]}}, rt};
  assign w_prod  = w_mul_a * w_mul_b;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero and
  // the remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case. The divisor is forced
  // to 1 on zero only to keep the datapath defined. A divide by zero never commits.
  assign w_a_neg  = ~w_unsigned & rs[31];
  assign w_b_neg  = ~w_unsigned & rt[31];
  assign w_a_mag  = w_a_neg ? (32'h0 - rs) : rs;
  assign w_b_mag  = w_b_neg ? (32'h0 - rt) : rt;
  assign w_b_zero = (rt == 32'h0);
  assign w_b_safe = w_b_zero ? 32'h1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'h0 - w_q_mag) : w_q_mag;
  assign w_rem    = w_a_neg ? (32'h0 - w_r_mag) : w_r_mag;

  // Next-state logic: accept or mthi/mtlo when idle, count down and commit when busy.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    w_res_wr_nxt = r_res_wr;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (MDOp)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              w_state_nxt = S_BUSY;
              if (w_is_div) begin
                w_cnt_nxt    = C_DIV_LOAD;
                w_res_hi_nxt = w_rem;
                w_res_lo_nxt = w_quot;
                w_res_wr_nxt = ~w_b_zero;
              end else begin
                w_cnt_nxt    = C_MULT_LOAD;
                w_res_hi_nxt = w_prod[63:32];
                w_res_lo_nxt = w_prod[31:0];
                w_res_wr_nxt = 1'b1;
              end
            end
            3'b100:  w_hi_nxt = rs;
            3'b101:  w_lo_nxt = rs;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - C_ONE;
        if (r_cnt == C_ONE) begin
          w_state_nxt = S_IDLE;
          if (r_res_wr) begin
            w_hi_nxt = r_res_hi;
            w_lo_nxt = r_res_lo;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, held result and HI/LO registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_res_wr <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
      r_res_wr <= w_res_wr_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign busy  = (r_state == S_BUSY);
  assign stall = busy | w_is_md;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
